prog_mod_counter: RTL and testbench

PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

---
 rtl/prog_mod_counter.sv | 88 ++++++++
 tb/tb_prog_mod_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with wrap, saturate and one-shot modes.
// count, tc and done are registered; the priority is rst > clear > load > counting.
module prog_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] L_RESET_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  mode_e            w_mode;
  logic             w_at_term;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;

  assign w_mode = mode_e'(mode);

  // Up direction treats any value at or above limit as terminal, so an
  // over-limit load wraps or saturates on the next enabled edge.
  assign w_at_term = up_dn ? (r_count >= limit) : (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    if (clear) begin
      w_count_nxt = L_RESET_VAL;
      w_done_nxt  = 1'b0;
    end else if (load) begin
      w_count_nxt = load_val;
      w_done_nxt  = 1'b0;
    end else if (en && !r_done) begin
      if (!w_at_term) begin
        w_count_nxt = up_dn ? r_count + 1'b1 : r_count - 1'b1;
      end else begin
        w_tc_nxt = 1'b1;
        unique case (w_mode)
          MODE_SAT:     w_count_nxt = r_count;
          MODE_ONESHOT: w_done_nxt  = 1'b1;
          MODE_WRAP,
          MODE_WRAP_ALT: w_count_nxt = up_dn ? '0 : limit;
          default:      w_count_nxt = r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= L_RESET_VAL;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: a 4-bit default instance and an 8-bit RESET_VAL=5
// instance, directed scenarios followed by random traffic against an integer model.
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_up, a_load, a_clear;
  logic [1:0] a_mode;
  logic [3:0] a_limit, a_load_val, a_count;
  logic       a_tc, a_done;

  logic       b_rst, b_en, b_up, b_load, b_clear;
  logic [1:0] b_mode;
  logic [7:0] b_limit, b_load_val, b_count;
  logic       b_tc, b_done;

  prog_mod_counter dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .mode(a_mode),
    .limit(a_limit), .load(a_load), .load_val(a_load_val), .clear(a_clear),
    .count(a_count), .tc(a_tc), .done(a_done)
  );

  prog_mod_counter #(.WIDTH(8), .RESET_VAL(5)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .mode(b_mode),
    .limit(b_limit), .load(b_load), .load_val(b_load_val), .clear(b_clear),
    .count(b_count), .tc(b_tc), .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  int ma_c, ma_t, ma_d;
  int mb_c, mb_t, mb_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: integer state, one call per rising edge.
  task automatic model_step(input int w, input int rv, input bit r, input bit c,
                            input bit l, input bit e, input bit ud, input int m,
                            input int lim, input int lv,
                            inout int cnt, inout int t, inout int d);
    int top;
    bit term;
    top = (1 << w) - 1;
    if (r || c) begin
      cnt = rv; t = 0; d = 0;
    end else if (l) begin
      cnt = lv; t = 0; d = 0;
    end else if (!e || d == 1) begin
      t = 0;
    end else begin
      term = ud ? (cnt >= lim) : (cnt == 0);
      if (!term) begin
        cnt = ud ? cnt + 1 : cnt - 1;
        t = 0;
      end else begin
        t = 1;
        if (m == 2) d = 1;
        else if (m != 1) cnt = ud ? 0 : lim;
      end
    end
    if (cnt < 0 || cnt > top) cnt = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(4, 0, a_rst, a_clear, a_load, a_en, a_up, int'(a_mode),
               int'(a_limit), int'(a_load_val), ma_c, ma_t, ma_d);
    model_step(8, 5, b_rst, b_clear, b_load, b_en, b_up, int'(b_mode),
               int'(b_limit), int'(b_load_val), mb_c, mb_t, mb_d);
    #1;
    chk("a_count", 32'(a_count), 32'(ma_c));
    chk("a_tc",    32'(a_tc),    32'(ma_t));
    chk("a_done",  32'(a_done),  32'(ma_d));
    chk("b_count", 32'(b_count), 32'(mb_c));
    chk("b_tc",    32'(b_tc),    32'(mb_t));
    chk("b_done",  32'(b_done),  32'(mb_d));
  endtask

  initial begin
    a_rst = 1; a_en = 0; a_up = 1; a_load = 0; a_clear = 0;
    a_mode = 2'b00; a_limit = 4'd13; a_load_val = '0;
    b_rst = 1; b_en = 0; b_up = 1; b_load = 0; b_clear = 0;
    b_mode = 2'b00; b_limit = 8'd255; b_load_val = '0;
    ma_c = 0; ma_t = 0; ma_d = 0;
    mb_c = 0; mb_t = 0; mb_d = 0;

    tick();
    chk("reset_a_count", 32'(a_count), 0);
    chk("reset_b_count", 32'(b_count), 5);
    chk("reset_a_tc", 32'(a_tc), 0);

    // legacy mod-14 up count from reset
    a_rst = 0; b_rst = 0; a_en = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("mod14_count", 32'(a_count), 32'(i % 14));
      chk("mod14_tc", 32'(a_tc), (i == 14) ? 1 : 0);
    end

    // saturate down
    a_en = 0; a_load = 1; a_load_val = 4'd2; tick();
    a_load = 0; a_mode = 2'b01; a_up = 0; a_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_count", 32'(a_count), (i == 0) ? 1 : 0);
      chk("sat_tc", 32'(a_tc), (i >= 2) ? 1 : 0);
    end
    a_en = 0; tick();
    chk("sat_idle_tc", 32'(a_tc), 0);
    chk("sat_idle_count", 32'(a_count), 0);

    // one-shot
    a_limit = 4'd12; a_load = 1; a_load_val = 4'd10; tick();
    a_load = 0; a_mode = 2'b10; a_up = 1; a_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("os_count", 32'(a_count), (i == 0) ? 11 : 12);
      chk("os_done", 32'(a_done), (i == 2) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      a_en = i[0]; tick();
      chk("os_hold", 32'(a_count), 12);
      chk("os_hold_tc", 32'(a_tc), 0);
    end
    a_clear = 1; tick();
    chk("os_clear_count", 32'(a_count), 0);
    chk("os_clear_done", 32'(a_done), 0);
    a_clear = 0;

    // priority rst > clear > load > count
    a_mode = 2'b00; a_limit = 4'd13;
    a_load = 1; a_load_val = 4'd7; a_clear = 1; a_en = 1; tick();
    chk("prio_clear", 32'(a_count), 0);
    a_clear = 0; tick();
    chk("prio_load", 32'(a_count), 7);
    a_rst = 1; tick();
    chk("prio_rst", 32'(a_count), 0);
    a_rst = 0; a_load = 0;

    // wrap down, then over-limit loads in both directions
    a_limit = 4'd9; a_up = 0; a_en = 1;
    tick(); chk("wrapdn_9", 32'(a_count), 9);
    chk("wrapdn_tc", 32'(a_tc), 1);
    tick(); chk("wrapdn_8", 32'(a_count), 8);
    a_en = 0; a_load = 1; a_load_val = 4'd14; tick();
    chk("ovl_load", 32'(a_count), 14);
    a_load = 0; a_up = 1; a_en = 1; tick();
    chk("ovl_up_count", 32'(a_count), 0);
    chk("ovl_up_tc", 32'(a_tc), 1);
    a_load = 1; tick();
    a_load = 0; a_up = 0; tick();
    chk("ovl_dn_count", 32'(a_count), 13);
    chk("ovl_dn_tc", 32'(a_tc), 0);

    // limit 0, up, wrap
    a_clear = 1; tick(); a_clear = 0;
    a_limit = 4'd0; a_up = 1; a_mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lim0_count", 32'(a_count), 0);
      chk("lim0_tc", 32'(a_tc), 1);
    end

    // 8-bit instance: reset mid-run and while done
    b_load = 1; b_load_val = 8'd200; tick();
    b_load = 0; b_en = 1; tick(); tick();
    chk("b_run", 32'(b_count), 202);
    b_rst = 1; tick();
    chk("b_rst_count", 32'(b_count), 5);
    chk("b_rst_tc", 32'(b_tc), 0);
    b_rst = 0; b_limit = 8'd10; b_mode = 2'b10; b_load = 1; b_load_val = 8'd9; tick();
    b_load = 0; tick(); tick();
    chk("b_os_done", 32'(b_done), 1);
    b_rst = 1; tick();
    chk("b_rst_done", 32'(b_done), 0);
    chk("b_rst_count2", 32'(b_count), 5);
    b_rst = 0; tick();
    chk("b_resume", 32'(b_count), 6);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      a_rst = ($urandom_range(0, 49) == 0);
      a_clear = ($urandom_range(0, 19) == 0);
      a_load = ($urandom_range(0, 9) == 0);
      a_en = ($urandom_range(0, 3) != 0);
      a_up = 1'($urandom);
      a_mode = 2'($urandom);
      a_limit = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      a_load_val = 4'($urandom);
      b_rst = ($urandom_range(0, 49) == 0);
      b_clear = ($urandom_range(0, 19) == 0);
      b_load = ($urandom_range(0, 9) == 0);
      b_en = ($urandom_range(0, 3) != 0);
      b_up = 1'($urandom);
      b_mode = 2'($urandom);
      b_limit = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      b_load_val = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
